selfwrite_streamer: RTL

Bitstream loader that drives the fabric's self-configuration port (`SelfWriteData`/`SelfWriteStrobe`) from a byte stream. It sits between a bitstream source (boot ROM reader, SPI flash reader or bench byte feeder) and `eFPGA_top`. It packs bytes MSB-first into 32-bit words and issues one strobe per word with fixed data-setup and inter-word gap timing. It is the hardware counterpart of the software/bench loader loop.

---
 rtl/selfwrite_streamer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/selfwrite_streamer.sv
// selfwrite_streamer: packs a byte stream MSB-first into 32-bit self-configuration words with setup/strobe/gap timing.
// Define SELFWRITE_PAD_FLUSH_EN to zero-pad and send a partial trailing word instead of discarding it.
module selfwrite_streamer #(
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] SelfWriteData,
  output logic        SelfWriteStrobe,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_sent,
  output logic        underrun_err
);
  typedef enum logic [2:0] {IDLE, COLLECT, SETUP, STROBE, GAP} state_t;
  localparam logic [15:0] SETUP_L = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] GAP_L   = 16'(GAP_CYCLES - 1);
  state_t state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] data_q, data_d, shifted;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [15:0] num_q, num_d, sent_q, sent_d, cnt_q, cnt_d;
  logic        last_q, last_d, done_q, done_d, err_q, err_d, finish;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    num_d   = num_q;
    sent_d  = sent_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;
    shifted = {shift_q, byte_data};
    finish  = last_q || (num_q != 16'd0 && sent_q == num_q);
    case (state_q)
      IDLE: if (start) begin
        state_d = COLLECT;
        done_d  = 1'b0;
        err_d   = 1'b0;
        sent_d  = 16'd0;
        num_d   = num_words;
        bcnt_d  = 2'd0;
        last_d  = 1'b0;
      end
      COLLECT: if (byte_valid) begin
        shift_d = shifted[23:0];
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          data_d  = shifted;
          last_d  = byte_last;
          cnt_d   = 16'd0;
          state_d = SETUP;
        end else if (byte_last) begin
`ifdef SELFWRITE_PAD_FLUSH_EN
          data_d  = shifted << {~bcnt_q, 3'b000};
          last_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = SETUP;
`else
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
`endif
        end
      end
      SETUP: if (cnt_q == SETUP_L) begin
        state_d = STROBE;
        sent_d  = sent_q + 16'd1;
      end else cnt_d = cnt_q + 16'd1;
      STROBE: if (GAP_CYCLES > 0) begin
        state_d = GAP;
        cnt_d   = 16'd0;
      end else begin
        state_d = finish ? IDLE : COLLECT;
        done_d  = finish;
      end
      GAP: if (cnt_q == GAP_L) begin
        state_d = finish ? IDLE : COLLECT;
        done_d  = finish;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      num_q   <= '0;
      sent_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign byte_ready      = state_q == COLLECT;
  assign SelfWriteStrobe = state_q == STROBE;
  assign busy            = state_q != IDLE;
  assign SelfWriteData   = data_q;
  assign done            = done_q;
  assign words_sent      = sent_q;
  assign underrun_err    = err_q;
endmodule
